// File: rtl/apb_regfile_slave_if.sv
// APB bus bundle between the AHB-to-APB bridge (master) and the register-file
// completer (slave). There is no pready/pslverr, so every transfer has zero
// wait states.
//   pselx   : one-hot bank select, NUM_SLV wide
//   penable : access-phase indicator
//   pwrite  : 1 = write, 0 = read
//   paddr   : byte address, bits [5:2] pick the register
//   pwdata  : write data
//   prdata  : registered read data from the completer
interface apb_regfile_slave_if #(
  parameter int NUM_SLV = 4
);
  logic [NUM_SLV-1:0] pselx;
  logic               penable;
  logic               pwrite;
  logic [31:0]        paddr;
  logic [31:0]        pwdata;
  logic [31:0]        prdata;

  modport master (output pselx, penable, pwrite, paddr, pwdata, input prdata);
  modport slave  (input pselx, penable, pwrite, paddr, pwdata, output prdata);
endinterface

// File: rtl/apb_regfile_slave.sv
// APB register-file completer: NUM_SLV banks of DEPTH 32-bit registers, one
// bank per pselx line. Writes commit on the access-phase edge; read data is
// captured on the setup-phase edge and held until the next read setup.
// Ports:
//   hclk     : clock, rising edge
//   hreset   : asynchronous active-high reset
//   bus      : APB slave modport (pselx, penable, pwrite, paddr, pwdata, prdata)
//   prot_err : one-cycle pulse after a protocol violation (checker builds only)
//   err_cnt  : saturating violation count (checker builds only)
// Build option: define APB_SLV_PROT_CHK_EN to compile in the protocol checker
// and the prot_err/err_cnt ports.
module apb_regfile_slave #(
  parameter int          NUM_SLV = 4,
  parameter int          DEPTH   = 16,  // power of two, 2..16
  parameter logic [31:0] RST_VAL = 32'h0
) (
  input  logic               hclk,
  input  logic               hreset,
  apb_regfile_slave_if.slave bus
`ifdef APB_SLV_PROT_CHK_EN
  ,
  output logic               prot_err,
  output logic [7:0]         err_cnt
`endif
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} phase_e;

  logic [NUM_SLV-1:0]         win;
  logic [NUM_SLV-1:0]         in_setup;
  logic [NUM_SLV-1:0][31:0]   bank_rd;
  logic [AW-1:0]              idx;
  logic [31:0]                rd_mux;
  logic                       rd_en;
  logic                       unused_addr;

  assign idx         = bus.paddr[AW+1:2];
  assign unused_addr = ^{bus.paddr[31:AW+2], bus.paddr[1:0]};

  // Lowest set select bit wins when the bus is multi-hot.
  assign win = bus.pselx & (~bus.pselx + NUM_SLV'(1));

`ifdef APB_SLV_PROT_CHK_EN
  logic [NUM_SLV-1:0] in_access;
`endif

  for (genvar i = 0; i < NUM_SLV; i++) begin : g_bank
    phase_e                  st_q, st_d;
    logic [DEPTH-1:0][31:0]  regs;

    // st_q is last cycle's phase; st_d is the phase of the current cycle,
    // so edge-triggered actions key off st_d.
    always_ff @(posedge hclk or posedge hreset)
      if (hreset) st_q <= IDLE;
      else        st_q <= st_d;

    always_comb begin
      st_d = st_q;
      case (st_q)
        IDLE:    if (bus.pselx[i]) st_d = SETUP;
        SETUP:   st_d = ACCESS;
        ACCESS:  if (!bus.pselx[i])    st_d = IDLE;
                 else if (!bus.penable) st_d = SETUP;
        default: st_d = IDLE;
      endcase
    end

    assign in_setup[i] = (st_d == SETUP);
`ifdef APB_SLV_PROT_CHK_EN
    assign in_access[i] = (st_d == ACCESS);
`endif

    always_ff @(posedge hclk or posedge hreset)
      if (hreset)
        regs <= {DEPTH{RST_VAL}};
      else if (win[i] && st_d == ACCESS && bus.pwrite)
        regs[idx] <= bus.pwdata;

    assign bank_rd[i] = regs[idx];
  end

  always_comb begin
    rd_en  = 1'b0;
    rd_mux = '0;
    for (int i = 0; i < NUM_SLV; i++)
      if (win[i] && in_setup[i] && !bus.pwrite) begin
        rd_en  = 1'b1;
        rd_mux = bank_rd[i];
      end
  end

  always_ff @(posedge hclk or posedge hreset)
    if (hreset)     bus.prdata <= '0;
    else if (rd_en) bus.prdata <= rd_mux;

`ifdef APB_SLV_PROT_CHK_EN
  logic [31:0] s_addr, s_wdata;
  logic        s_write;
  logic        viol;

  // Snapshot of the setup-phase controls, compared during the access phase.
  always_ff @(posedge hclk or posedge hreset)
    if (hreset) begin
      s_addr  <= '0;
      s_wdata <= '0;
      s_write <= 1'b0;
    end else if (|in_setup) begin
      s_addr  <= bus.paddr;
      s_wdata <= bus.pwdata;
      s_write <= bus.pwrite;
    end

  always_comb begin
    viol = 1'b0;
    // penable high with no bank in access: either unselected or first cycle.
    if (bus.penable && !(|in_access)) viol = 1'b1;
    // Access entered only from setup when penable is low.
    if ((|in_access) && !bus.penable) viol = 1'b1;
    if ((|in_access) && (bus.paddr != s_addr || bus.pwrite != s_write ||
                         bus.pwdata != s_wdata)) viol = 1'b1;
    if (|(bus.pselx & (bus.pselx - NUM_SLV'(1)))) viol = 1'b1;
  end

  always_ff @(posedge hclk or posedge hreset)
    if (hreset) begin
      prot_err <= 1'b0;
      err_cnt  <= '0;
    end else begin
      prot_err <= viol;
      if (viol && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_apb_regfile_slave.sv
module tb_apb_regfile_slave;
  logic hclk = 1'b0;
  logic hreset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 hclk = ~hclk;

  apb_regfile_slave_if #(.NUM_SLV(4)) bus ();

`ifdef APB_SLV_PROT_CHK_EN
  logic       prot_err;
  logic [7:0] err_cnt;
`endif

  apb_regfile_slave #(.NUM_SLV(4), .DEPTH(16), .RST_VAL(32'h0)) dut (
    .hclk    (hclk),
    .hreset  (hreset),
    .bus     (bus)
`ifdef APB_SLV_PROT_CHK_EN
    ,
    .prot_err(prot_err),
    .err_cnt (err_cnt)
`endif
  );

  task automatic bus_idle();
    @(negedge hclk);
    bus.pselx   = '0;
    bus.penable = 1'b0;
  endtask

  task automatic apb_wr(input logic [3:0] sel, input logic [31:0] addr,
                        input logic [31:0] data);
    @(negedge hclk);
    bus.pselx = sel; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = addr; bus.pwdata = data;
    @(negedge hclk);
    bus.penable = 1'b1;
  endtask

  // Returns prdata sampled mid access phase.
  task automatic apb_rd(input logic [3:0] sel, input logic [31:0] addr,
                        output logic [31:0] d);
    @(negedge hclk);
    bus.pselx = sel; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = addr; bus.pwdata = '0;
    @(negedge hclk);
    bus.penable = 1'b1;
    d = bus.prdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    hreset = 1'b1;
    repeat (2) @(negedge hclk);
    n_tests++;
    if (bus.prdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_prdata got %h want %h", bus.prdata, 32'h0);
    end
    hreset = 1'b0;
    for (int r = 0; r < 16; r++) begin
      apb_rd(4'b0001, 32'(r * 4), d);
      n_tests++;
      if (d !== 32'h0) begin
        n_fail++; $display("FAIL reset_reg%0d got %h want %h", r, d, 32'h0);
      end
    end
    bus_idle();
  endtask

  task automatic test_write_read();
    logic [31:0] d;
    logic [3:0]  other [3];
    other[0] = 4'b0001; other[1] = 4'b0010; other[2] = 4'b1000;
    apb_wr(4'b0100, 32'h8000_0014, 32'hDEAD_BEEF);
    bus_idle();
    apb_rd(4'b0100, 32'h0000_0014, d);
    n_tests++;
    if (d !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL wr_rd_bank2 got %h want %h", d, 32'hDEAD_BEEF);
    end
    bus_idle();
    repeat (2) @(negedge hclk);
    n_tests++;
    if (bus.prdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL prdata_hold got %h want %h", bus.prdata, 32'hDEAD_BEEF);
    end
    for (int k = 0; k < 3; k++) begin
      apb_rd(other[k], 32'h14, d);
      n_tests++;
      if (d !== 32'h0) begin
        n_fail++; $display("FAIL other_bank sel=%b got %h want %h", other[k], d, 32'h0);
      end
    end
    apb_rd(4'b0100, 32'h10, d);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL bank2_reg4 got %h want %h", d, 32'h0);
    end
    bus_idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    apb_wr(4'b0001, 32'h08, 32'h1234_5678);
    apb_rd(4'b0001, 32'h08, d);
    n_tests++;
    if (d !== 32'h1234_5678) begin
      n_fail++; $display("FAIL b2b_rd got %h want %h", d, 32'h1234_5678);
    end
    bus_idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    apb_wr(4'b1000, 32'h04, 32'hFFFF_FFFF);
    hreset = 1'b1;                    // asserted during the access cycle
    @(negedge hclk);
    n_tests++;
    if (bus.prdata !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_prdata got %h want %h", bus.prdata, 32'h0);
    end
    bus.pselx = '0; bus.penable = 1'b0; hreset = 1'b0;
    apb_rd(4'b1000, 32'h04, d);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_reg got %h want %h", d, 32'h0);
    end
    bus_idle();
    apb_rd(4'b0001, 32'h08, d);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_clears_bank0 got %h want %h", d, 32'h0);
    end
    bus_idle();
    apb_wr(4'b1000, 32'h04, 32'h0000_1111);
    bus_idle();
    apb_rd(4'b1000, 32'h04, d);
    n_tests++;
    if (d !== 32'h0000_1111) begin
      n_fail++; $display("FAIL post_rst_xfer got %h want %h", d, 32'h0000_1111);
    end
    bus_idle();
  endtask

`ifdef APB_SLV_PROT_CHK_EN
  task automatic test_prot_chk();
    @(negedge hclk);
    bus.pselx = '0; bus.penable = 1'b1;
    @(negedge hclk);
    bus.penable = 1'b0;
    n_tests++;
    if (prot_err !== 1'b1) begin
      n_fail++; $display("FAIL prot_idle_pen got %b want 1", prot_err);
    end
    @(negedge hclk);
    bus.pselx = 4'b0001; bus.pwrite = 1'b0; bus.paddr = 32'h0; bus.pwdata = '0;
    n_tests++;
    if (prot_err !== 1'b0) begin
      n_fail++; $display("FAIL prot_quiet got %b want 0", prot_err);
    end
    @(negedge hclk);                  // penable stays low after setup
    @(negedge hclk);
    bus.pselx = '0;
    n_tests++;
    if (prot_err !== 1'b1 || err_cnt !== 8'd2) begin
      n_fail++; $display("FAIL prot_no_enable got %b/%0d want 1/2", prot_err, err_cnt);
    end
    @(negedge hclk);
    n_tests++;
    if (prot_err !== 1'b0 || err_cnt !== 8'd2) begin
      n_fail++; $display("FAIL prot_pulse_end got %b/%0d want 0/2", prot_err, err_cnt);
    end
    bus.penable = 1'b1;
    repeat (10) @(negedge hclk);
    n_tests++;
    if (err_cnt !== 8'd12) begin
      n_fail++; $display("FAIL err_cnt_12 got %0d want 12", err_cnt);
    end
    repeat (290) @(negedge hclk);
    bus.penable = 1'b0;
    @(negedge hclk);
    n_tests++;
    if (err_cnt !== 8'hFF || prot_err !== 1'b0) begin
      n_fail++; $display("FAIL err_cnt_sat got %h/%b want ff/0", err_cnt, prot_err);
    end
  endtask
`endif

  task automatic test_multihot();
    logic [31:0] d;
    apb_wr(4'b0011, 32'h0, 32'hA5A5_A5A5);
`ifdef APB_SLV_PROT_CHK_EN
    n_tests++;
    if (prot_err !== 1'b1 || err_cnt !== 8'hFF) begin
      n_fail++; $display("FAIL multihot_prot got %b/%h want 1/ff", prot_err, err_cnt);
    end
`endif
    bus_idle();
    apb_rd(4'b0001, 32'h0, d);
    n_tests++;
    if (d !== 32'hA5A5_A5A5) begin
      n_fail++; $display("FAIL multihot_bank0 got %h want %h", d, 32'hA5A5_A5A5);
    end
    bus_idle();
    apb_rd(4'b0010, 32'h0, d);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL multihot_bank1 got %h want %h", d, 32'h0);
    end
    bus_idle();
  endtask

  initial begin
    hreset = 1'b1;
    bus.pselx = '0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_reset_mid();
`ifdef APB_SLV_PROT_CHK_EN
    test_prot_chk();
`endif
    test_multihot();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
